rtc_bus_sequencer: RTL and testbench
====================================

RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Clocking and reset SHALL be: one clock `clk`; reset `reset` is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- NUM_REGS, 9, registers per burst (1..16).
- DATA_W, 8, bus/data width.
- T_SU, 2, cycles cs low before strobe.
- T_PW, 4, strobe-low cycles.
- T_HD, 2, cycles after strobe before phase end.
- REFRESH_CYC, 1000, idle cycles between auto-read bursts (0 disables).
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, async active-low reset.
- start_rd, in, 1, pulse: read burst.
- start_wr, in, 1, pulse: masked write burst.
- start_cmd, in, 1, pulse: single write of cmd_data to cmd_addr.
- refresh_en, in, 1, enables auto-read.
- reg_addr, in, NUM_REGS*DATA_W, per-register RTC address table.
- wr_data, in, NUM_REGS*DATA_W, write values.
- wr_mask, in, NUM_REGS, 1 = write register i.
- cmd_addr, in, DATA_W, command address.
- cmd_data, in, DATA_W, command data.
- ad_in, in, DATA_W, bus read value from external tri-state.
- ad_out, out, DATA_W, bus drive value.
- ad_oe, out, 1, tri-state enable.
- a_d, out, 1, 0 = address phase, 1 = data phase.
- cs, out, 1, active-low chip select.
- rd, out, 1, active-low read strobe.
- wr, out, 1, active-low write strobe.
- rd_data, out, NUM_REGS*DATA_W, captured read values.
- rd_update, out, 1, pulse: read burst complete.
- busy, out, 1, transaction in progress.
- done, out, 1, pulse: any burst complete.

Function
REQ-004 FSM states SHALL be: IDLE, ADDR_SU, ADDR_PW, ADDR_HD, DATA_SU, DATA_PW, DATA_HD, NEXT, FINISH.
REQ-005 Each phase SHALL last T_SU + T_PW + T_HD cycles; one register access is two phases (default 16 cycles).
REQ-006 Address phase: a_d=0, cs=0, wr=0 during ADDR_PW, ad_oe=1, ad_out=address.
REQ-007 Data phase: a_d=1, cs=0; write drives ad_out/ad_oe=1 with wr=0 during DATA_PW; read sets ad_oe=0 with rd=0 during DATA_PW.
REQ-008 Read capture SHALL sample ad_in into rd_data slot i on the last DATA_PW cycle.
REQ-009 Starts SHALL be accepted only in IDLE; starts while busy are ignored, not queued.
REQ-010 Simultaneous start priority SHALL be: start_cmd > start_wr > start_rd > pending refresh.
REQ-011 Registers SHALL be walked from index 0 upward; a write burst skips indices with wr_mask=0 at no cycle cost (NEXT selects the next set bit).
REQ-012 All-zero wr_mask SHALL cause FINISH the cycle after acceptance, with no cs activity.
REQ-013 reg_addr, wr_data, wr_mask and cmd_* SHALL be latched at acceptance; later changes have no effect on the running burst.
REQ-014 busy SHALL be 1 from the cycle after acceptance through FINISH.
REQ-015 done SHALL pulse one cycle in FINISH; rd_update SHALL pulse with done for read/refresh bursts only.
REQ-016 Burst latency SHALL be done exactly 16*k+1 cycles after the accepting edge at default timing, k = registers accessed.
REQ-017 Refresh counter SHALL count only in IDLE with refresh_en=1, set a pending flag at REFRESH_CYC-1, clear on any accepted start, and reload.
REQ-018 cs/rd/wr SHALL never be low in IDLE or FINISH; rd and wr SHALL never be low simultaneously.

Reset
REQ-019 Reset assertion SHALL immediately force: state IDLE, cs=rd=wr=1, a_d=1, ad_oe=0, ad_out=0, rd_data=0, busy=done=rd_update=0, refresh counter=0, pending=0.
REQ-020 Reset mid-burst SHALL abort without completion pulse; rd_data SHALL be cleared, not partially retained.

Structure
REQ-021 The state encoding and the default timing constants SHALL reside in shared package rtc_bus_pkg.
REQ-022 Phase sequencing SHALL use one sub-module, rtc_bus_phase_timer, to generate su/pw/hd timing and a phase_end pulse.

Verification
REQ-023 Directed scenarios (default parameters):
- start_rd with ad_in=8'h45 -> 9 accesses, rd_data all 8'h45, done and rd_update at cycle 145.
- start_wr with wr_mask=9'b000000101 -> wr pulses only for indices 0 and 2, done at cycle 33, rd_update=0.
- start_cmd(8'h02, 8'h10) together with start_rd -> single write of 8'h10 to 8'h02; start_rd dropped.
- wr_mask=0 -> done at cycle 2, cs stays 1.
- Reset asserted at cycle 40 of a read -> outputs at reset values the same cycle, no done.
- REFRESH_CYC=20, refresh_en=1 -> read burst begins after 20 idle cycles; start_wr arriving first wins.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared state encoding, operation codes and default bus timing for the RTC bus sequencer.
package rtc_bus_pkg;

    localparam int NUM_REGS_DEF = 9;
    localparam int DATA_W_DEF   = 8;
    localparam int T_SU_DEF     = 2;
    localparam int T_PW_DEF     = 4;
    localparam int T_HD_DEF     = 2;
    localparam int REFRESH_DEF  = 1000;

    typedef enum logic [3:0] {
        IDLE, ADDR_SU, ADDR_PW, ADDR_HD, DATA_SU, DATA_PW, DATA_HD, NEXT, FINISH
    } state_t;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_CMD} op_t;

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Cycle counter for one bus phase: setup, strobe and hold windows, with end-of-window pulses.
module rtc_bus_phase_timer #(
    parameter int T_SU = 2,
    parameter int T_PW = 4,
    parameter int T_HD = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic su_end,
    output logic pw_end,
    output logic phase_end
);
    localparam int LEN = T_SU + T_PW + T_HD;
    localparam int CW  = $clog2(LEN + 1);

    logic [CW-1:0] cnt;

    // Counter wraps at phase end so back-to-back phases need no idle cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   cnt <= '0;
        else if (!active || phase_end) cnt <= '0;
        else                          cnt <= cnt + CW'(1);
    end

    assign su_end    = active && (cnt == CW'(T_SU - 1));
    assign pw_end    = active && (cnt == CW'(T_SU + T_PW - 1));
    assign phase_end = active && (cnt == CW'(LEN - 1));

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data RTC bus master: read bursts, masked write bursts, single commands, auto-refresh.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int T_SU        = T_SU_DEF,
    parameter int T_PW        = T_PW_DEF,
    parameter int T_HD        = T_HD_DEF,
    parameter int REFRESH_CYC = REFRESH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_rd,
    input  logic                       start_wr,
    input  logic                       start_cmd,
    input  logic                       refresh_en,
    input  logic [NUM_REGS*DATA_W-1:0] reg_addr,
    input  logic [NUM_REGS*DATA_W-1:0] wr_data,
    input  logic [NUM_REGS-1:0]        wr_mask,
    input  logic [DATA_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic [DATA_W-1:0]          ad_in,
    output logic [DATA_W-1:0]          ad_out,
    output logic                       ad_oe,
    output logic                       a_d,
    output logic                       cs,
    output logic                       rd,
    output logic                       wr,
    output logic [NUM_REGS*DATA_W-1:0] rd_data,
    output logic                       rd_update,
    output logic                       busy,
    output logic                       done
);
    localparam int IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int RW     = $clog2(REFRESH_CYC + 2);
    localparam bit REF_ON = (REFRESH_CYC > 0);

    state_t                           state, state_nxt;
    op_t                              op, acc_op;
    logic [NUM_REGS-1:0][DATA_W-1:0]  addr_q, data_q, cap;
    logic [NUM_REGS-1:0]              mask_q, acc_mask;
    logic [IW-1:0]                    idx;
    logic [IW:0]                      first, nxt;
    logic [RW-1:0]                    ref_cnt;
    logic                             pending, accept, in_phase;
    logic                             su_end, pw_end, phase_end;

    // Returns {found, index} of the lowest set bit at or above lo.
    function automatic logic [IW:0] find_set(input logic [NUM_REGS-1:0] m, input int lo);
        logic [IW:0] r;
        r = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (m[i] && i >= lo) r = {1'b1, IW'(i)};
        return r;
    endfunction

    always_comb begin
        accept   = 1'b0;
        acc_op   = OP_RD;
        acc_mask = '1;
        if (state == IDLE) begin
            if (start_cmd) begin
                accept = 1'b1; acc_op = OP_CMD; acc_mask = NUM_REGS'(1);
            end else if (start_wr) begin
                accept = 1'b1; acc_op = OP_WR; acc_mask = wr_mask;
            end else if (start_rd || (pending && refresh_en)) begin
                accept = 1'b1;
            end
        end
    end

    assign first    = find_set(acc_mask, 0);
    assign nxt      = find_set(mask_q, int'(idx) + 1);
    assign in_phase = state inside {ADDR_SU, ADDR_PW, ADDR_HD, DATA_SU, DATA_PW, DATA_HD};

    rtc_bus_phase_timer #(.T_SU(T_SU), .T_PW(T_PW), .T_HD(T_HD)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .active    (in_phase),
        .su_end    (su_end),
        .pw_end    (pw_end),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = first[IW] ? ADDR_SU : NEXT;
            ADDR_SU: if (su_end)    state_nxt = ADDR_PW;
            ADDR_PW: if (pw_end)    state_nxt = ADDR_HD;
            ADDR_HD: if (phase_end) state_nxt = DATA_SU;
            DATA_SU: if (su_end)    state_nxt = DATA_PW;
            DATA_PW: if (pw_end)    state_nxt = DATA_HD;
            DATA_HD: if (phase_end) state_nxt = nxt[IW] ? ADDR_SU : FINISH;
            NEXT:                   state_nxt = nxt[IW] ? ADDR_SU : FINISH;
            FINISH:                 state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Command reuses slot 0 of the latched tables so the burst walker handles it unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op     <= OP_RD;
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
            idx    <= '0;
            cap    <= '0;
        end else begin
            if (accept) begin
                op     <= acc_op;
                mask_q <= acc_mask;
                addr_q <= reg_addr;
                data_q <= wr_data;
                idx    <= first[IW-1:0];
                if (acc_op == OP_CMD) begin
                    addr_q[0] <= cmd_addr;
                    data_q[0] <= cmd_data;
                end
            end else if (((state == DATA_HD && phase_end) || state == NEXT) && nxt[IW]) begin
                idx <= nxt[IW-1:0];
            end
            if (state == DATA_PW && pw_end && op == OP_RD) cap[idx] <= ad_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt <= '0;
            pending <= 1'b0;
        end else if (accept) begin
            ref_cnt <= '0;
            pending <= 1'b0;
        end else if (REF_ON && state == IDLE && refresh_en && !pending) begin
            if (ref_cnt == RW'(REFRESH_CYC - 1)) begin
                pending <= 1'b1;
                ref_cnt <= '0;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
        end
    end

    always_comb begin
        cs     = 1'b1;
        rd     = 1'b1;
        wr     = 1'b1;
        a_d    = 1'b1;
        ad_oe  = 1'b0;
        ad_out = '0;
        case (state)
            ADDR_SU, ADDR_PW, ADDR_HD: begin
                cs     = 1'b0;
                a_d    = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q[idx];
                wr     = (state != ADDR_PW);
            end
            DATA_SU, DATA_PW, DATA_HD: begin
                cs = 1'b0;
                if (op == OP_RD) begin
                    rd = (state != DATA_PW);
                end else begin
                    ad_oe  = 1'b1;
                    ad_out = data_q[idx];
                    wr     = (state != DATA_PW);
                end
            end
            default: ;
        endcase
    end

    assign rd_data   = cap;
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign rd_update = (state == FINISH) && (op == OP_RD);

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: burst latency, strobes, priority, reset abort and auto-refresh.
module tb_rtc_bus_sequencer;
    localparam int NR = 9;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset;
    logic start_rd, start_wr, start_cmd, refresh_en;
    logic start_rd2, start_wr2, start_cmd2, refresh_en2;
    logic [NR*DW-1:0] reg_addr, wr_data;
    logic [NR-1:0]    wr_mask;
    logic [DW-1:0]    cmd_addr, cmd_data, ad_in;

    logic [DW-1:0]    ad_out, ad_out2;
    logic             ad_oe, a_d, cs, rd, wr, rd_update, busy, done;
    logic             ad_oe2, a_d2, cs2, rd2, wr2, rd_update2, busy2, done2;
    logic [NR*DW-1:0] rd_data, rd_data2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] addr_log[$];
    logic [7:0] wdat_log[$];
    int         rd_pulses;
    bit         cs_seen, bad_seen, busy_c1;

    always #5 clk = ~clk;

    rtc_bus_sequencer dut (
        .clk(clk), .reset(reset), .start_rd(start_rd), .start_wr(start_wr),
        .start_cmd(start_cmd), .refresh_en(refresh_en), .reg_addr(reg_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs(cs), .rd(rd),
        .wr(wr), .rd_data(rd_data), .rd_update(rd_update), .busy(busy), .done(done)
    );

    rtc_bus_sequencer #(.REFRESH_CYC(20)) dut2 (
        .clk(clk), .reset(reset), .start_rd(start_rd2), .start_wr(start_wr2),
        .start_cmd(start_cmd2), .refresh_en(refresh_en2), .reg_addr(reg_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .ad_in(ad_in), .ad_out(ad_out2), .ad_oe(ad_oe2), .a_d(a_d2), .cs(cs2), .rd(rd2),
        .wr(wr2), .rd_data(rd_data2), .rd_update(rd_update2), .busy(busy2), .done(done2)
    );

    task automatic load_tables();
        for (int i = 0; i < NR; i++) begin
            reg_addr[i*DW +: DW] = 8'(8'h10 + i);
            wr_data[i*DW +: DW]  = 8'(8'hA0 + i);
        end
    endtask

    // Pulses the chosen starts, then watches the bus each cycle until done (bounded).
    task automatic run_burst(input bit s_rd, input bit s_wr, input bit s_cmd, input bit scramble,
                             output int cyc, output logic upd);
        logic prev_wr, prev_rd;
        addr_log.delete();
        wdat_log.delete();
        rd_pulses = 0; cs_seen = 0; bad_seen = 0; busy_c1 = 0;
        @(negedge clk);
        start_rd = s_rd; start_wr = s_wr; start_cmd = s_cmd;
        @(negedge clk);
        start_rd = 0; start_wr = 0; start_cmd = 0;
        if (scramble) begin
            reg_addr = ~reg_addr; wr_data = ~wr_data; wr_mask = ~wr_mask;
            cmd_addr = ~cmd_addr; cmd_data = ~cmd_data;
        end
        cyc = 1; prev_wr = 1; prev_rd = 1; upd = 0;
        while (cyc < 400) begin
            if (cyc == 1) busy_c1 = busy;
            if (!cs) cs_seen = 1;
            if (!rd && !wr) bad_seen = 1;
            if (!rd && ad_oe) bad_seen = 1;
            if (!wr && !ad_oe) bad_seen = 1;
            if (done && (!cs || !rd || !wr)) bad_seen = 1;
            if (!wr && prev_wr) begin
                if (a_d) wdat_log.push_back(ad_out);
                else     addr_log.push_back(ad_out);
            end
            if (!rd && prev_rd) rd_pulses++;
            prev_wr = wr; prev_rd = rd;
            if (done) begin
                upd = rd_update;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 0;
        start_rd = 0; start_wr = 0; start_cmd = 0; refresh_en = 0;
        start_rd2 = 0; start_wr2 = 0; start_cmd2 = 0; refresh_en2 = 0;
        reg_addr = '0; wr_data = '0; wr_mask = '0; cmd_addr = '0; cmd_data = '0; ad_in = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cs, rd, wr, a_d, ad_oe, busy, done, rd_update} !== 8'b1111_0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 11110000", {cs, rd, wr, a_d, ad_oe, busy, done, rd_update});
        end
        n_cmp++;
        if (ad_out !== 8'h00 || rd_data !== '0) begin
            n_err++; $display("FAIL reset_data: got ad_out=%h rd_data=%h want 0", ad_out, rd_data);
        end
        n_cmp++;
        if ({busy2, cs2} !== 2'b01) begin
            n_err++; $display("FAIL reset_dut2: got busy/cs=%b want 01", {busy2, cs2});
        end
        reset = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, cs, done} !== 3'b010) begin
            n_err++; $display("FAIL idle_after_reset: got busy/cs/done=%b want 010", {busy, cs, done});
        end
    endtask

    task automatic test_read_burst();
        int cyc; logic upd; bit ok;
        load_tables();
        ad_in = 8'h45;
        run_burst(1, 0, 0, 0, cyc, upd);
        n_cmp++;
        if (cyc !== 145) begin n_err++; $display("FAIL rd_latency: got %0d want 145", cyc); end
        n_cmp++;
        if (upd !== 1'b1) begin n_err++; $display("FAIL rd_update: got %b want 1", upd); end
        n_cmp++;
        if (rd_data !== {9{8'h45}}) begin n_err++; $display("FAIL rd_data: got %h want all 45", rd_data); end
        n_cmp++;
        if (rd_pulses !== 9) begin n_err++; $display("FAIL rd_pulses: got %0d want 9", rd_pulses); end
        ok = (addr_log.size() == 9);
        for (int i = 0; i < addr_log.size() && i < 9; i++) if (addr_log[i] !== 8'(8'h10 + i)) ok = 0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rd_addr_seq: got %0d addresses, want 10..18 in order", addr_log.size()); end
        n_cmp++;
        if ({bad_seen, busy_c1, cs_seen} !== 3'b011) begin
            n_err++; $display("FAIL rd_bus_rules: got bad/busy1/cs=%b want 011", {bad_seen, busy_c1, cs_seen});
        end
    endtask

    task automatic test_masked_write();
        int cyc; logic upd;
        load_tables();
        wr_mask = 9'b000000101;
        ad_in = 8'h99;
        run_burst(0, 1, 0, 1, cyc, upd);
        n_cmp++;
        if (cyc !== 33) begin n_err++; $display("FAIL wr_latency: got %0d want 33", cyc); end
        n_cmp++;
        if (upd !== 1'b0) begin n_err++; $display("FAIL wr_rd_update: got %b want 0", upd); end
        n_cmp++;
        if (wdat_log.size() != 2 || wdat_log[0] !== 8'hA0 || wdat_log[1] !== 8'hA2) begin
            n_err++; $display("FAIL wr_data_seq: got %0d writes (first %h), want A0,A2", wdat_log.size(),
                              (wdat_log.size() > 0) ? wdat_log[0] : 8'hxx);
        end
        n_cmp++;
        if (addr_log.size() != 2 || addr_log[0] !== 8'h10 || addr_log[1] !== 8'h12) begin
            n_err++; $display("FAIL wr_addr_seq: got %0d addresses, want 10,12", addr_log.size());
        end
        n_cmp++;
        if (rd_pulses !== 0 || bad_seen) begin
            n_err++; $display("FAIL wr_strobes: got rd_pulses=%0d bad=%b want 0/0", rd_pulses, bad_seen);
        end
        n_cmp++;
        if (rd_data !== {9{8'h45}}) begin n_err++; $display("FAIL wr_keeps_rd_data: got %h want all 45", rd_data); end
    endtask

    task automatic test_cmd_priority();
        int cyc; logic upd;
        load_tables();
        cmd_addr = 8'h02;
        cmd_data = 8'h10;
        run_burst(1, 0, 1, 0, cyc, upd);
        n_cmp++;
        if (cyc !== 17) begin n_err++; $display("FAIL cmd_latency: got %0d want 17", cyc); end
        n_cmp++;
        if (addr_log.size() != 1 || wdat_log.size() != 1 || addr_log[0] !== 8'h02 || wdat_log[0] !== 8'h10) begin
            n_err++; $display("FAIL cmd_write: got %0d addr / %0d data entries, want one 02/10", addr_log.size(), wdat_log.size());
        end
        n_cmp++;
        if (rd_pulses !== 0 || upd !== 1'b0) begin
            n_err++; $display("FAIL cmd_no_read: got rd_pulses=%0d upd=%b want 0/0", rd_pulses, upd);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL cmd_rd_dropped: got busy=%b want 0", busy); end
    endtask

    task automatic test_zero_mask();
        int cyc; logic upd;
        wr_mask = '0;
        run_burst(0, 1, 0, 0, cyc, upd);
        n_cmp++;
        if (cyc !== 2) begin n_err++; $display("FAIL zero_mask_latency: got %0d want 2", cyc); end
        n_cmp++;
        if (cs_seen || upd !== 1'b0 || wdat_log.size() != 0) begin
            n_err++; $display("FAIL zero_mask_bus: got cs_seen=%b upd=%b writes=%0d want 0/0/0", cs_seen, upd, wdat_log.size());
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic upd;
        load_tables();
        ad_in = 8'h3C;
        @(negedge clk); start_rd = 1;
        @(negedge clk); start_rd = 0;
        cyc = 1;
        while (!done && cyc < 400) begin
            start_cmd = (cyc == 3);
            start_wr  = (cyc == 144);
            @(negedge clk);
            cyc++;
        end
        start_cmd = 0; start_wr = 0;
        n_cmp++;
        if (cyc !== 145) begin n_err++; $display("FAIL busy_ignore_latency: got %0d want 145", cyc); end
        n_cmp++;
        if (rd_data !== {9{8'h3C}}) begin n_err++; $display("FAIL busy_ignore_data: got %h want all 3C", rd_data); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_not_queued: got busy=%b want 0", busy); end
        wr_mask = 9'b100000000;
        run_burst(0, 1, 0, 0, cyc, upd);
        n_cmp++;
        if (cyc !== 17 || addr_log.size() != 1 || addr_log[0] !== 8'h18 || wdat_log.size() != 1 || wdat_log[0] !== 8'hA8) begin
            n_err++; $display("FAIL top_index_write: got cyc=%0d entries=%0d want 17 with 18/A8", cyc, addr_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit done_seen;
        ad_in = 8'h77;
        @(negedge clk); start_rd = 1;
        @(negedge clk); start_rd = 0;
        cyc = 1;
        while (cyc < 40) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (rd_data[15:0] !== 16'h7777 || busy !== 1'b1) begin
            n_err++; $display("FAIL mid_partial: got rd_data[15:0]=%h busy=%b want 7777/1", rd_data[15:0], busy);
        end
        reset = 0;
        #1;
        n_cmp++;
        if ({cs, rd, wr, a_d, ad_oe, busy, done, rd_update} !== 8'b1111_0000 || ad_out !== 8'h00) begin
            n_err++; $display("FAIL mid_reset_ctrl: got %b ad_out=%h want 11110000/00",
                              {cs, rd, wr, a_d, ad_oe, busy, done, rd_update}, ad_out);
        end
        n_cmp++;
        if (rd_data !== '0) begin n_err++; $display("FAIL mid_reset_clear: got %h want 0", rd_data); end
        @(negedge clk);
        reset = 1;
        done_seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (done || busy) done_seen = 1;
        end
        n_cmp++;
        if (done_seen) begin n_err++; $display("FAIL mid_no_done: got activity after abort, want none"); end
    endtask

    task automatic test_refresh();
        int cyc; bit early;
        load_tables();
        ad_in = 8'h5A;
        @(negedge clk); refresh_en2 = 1;
        early = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy2) early = 1;
        end
        n_cmp++;
        if (early) begin n_err++; $display("FAIL refresh_early: got busy before 20 idle cycles, want idle"); end
        @(negedge clk);
        n_cmp++;
        if (busy2 !== 1'b1) begin n_err++; $display("FAIL refresh_start: got busy=%b want 1", busy2); end
        cyc = 1;
        while (!done2 && cyc < 400) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (cyc !== 145 || rd_update2 !== 1'b1) begin
            n_err++; $display("FAIL refresh_burst: got cyc=%0d upd=%b want 145/1", cyc, rd_update2);
        end
        n_cmp++;
        if (rd_data2 !== {9{8'h5A}}) begin n_err++; $display("FAIL refresh_data: got %h want all 5A", rd_data2); end
        repeat (10) @(negedge clk);
        wr_mask = 9'b000000001;
        start_wr2 = 1;
        @(negedge clk); start_wr2 = 0;
        cyc = 1;
        while (!done2 && cyc < 400) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (cyc !== 17 || rd_update2 !== 1'b0) begin
            n_err++; $display("FAIL refresh_wr_wins: got cyc=%0d upd=%b want 17/0", cyc, rd_update2);
        end
        early = 0;
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk);
            if (busy2) early = 1;
        end
        n_cmp++;
        if (early) begin n_err++; $display("FAIL refresh_reload: got busy within 20 idle cycles after write, want idle"); end
        @(negedge clk);
        n_cmp++;
        if (busy2 !== 1'b1) begin n_err++; $display("FAIL refresh_restart: got busy=%b want 1", busy2); end
        refresh_en2 = 0;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_masked_write();
        test_cmd_priority();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid();
        test_refresh();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
